mul_accumulator: RTL and testbench

MUL_ACCUMULATOR -- requirements
Module: mul_accumulator

---
 rtl/mul_accumulator_pkg.sv | 14 +
 rtl/mul_accumulator_if.sv | 26 ++
 rtl/mul_accumulator_beat_counter.sv | 28 ++
 rtl/mul_accumulator.sv | 78 +++++++
 tb/tb_mul_accumulator.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/mul_accumulator_pkg.sv
// Shared constants and state encoding for the multiply-accumulate run controller.
package mul_accumulator_pkg;

  localparam int ACC_W_DEF = 12;
  localparam int LEN_W     = 4;
  localparam int PROD_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mul_accumulator_if.sv
// Product stream and result bus between the upstream multiplier/controller and the accumulator.
interface mul_accumulator_if
  import mul_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [PROD_W-1:0] prod;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              busy;
  logic              ovf;

  modport master (
    output start, len, prod, prod_valid,
    input  prod_ready, acc_out, acc_valid, busy, ovf
  );

  modport slave (
    input  start, len, prod, prod_valid,
    output prod_ready, acc_out, acc_valid, busy, ovf
  );
endinterface

// File: rtl/mul_accumulator_beat_counter.sv
// Remaining-beat counter: loads len at run start, counts down on each non-final beat.
module beat_counter
  import mul_accumulator_pkg::*;
#(
  parameter int W = LEN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mul_accumulator.sv
// Accumulates a run of len+1 unsigned 8-bit products; pulses acc_valid once with the
// modulo-2^ACC_W sum and keeps a sticky overflow flag for the run.
module mul_accumulator
  import mul_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mul_accumulator_if.slave   bus
);
  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             w_start;
  logic             w_beat;
  logic             w_zero;
  logic [ACC_W:0]   w_sum;

  // Extra top bit carries the true-sum overflow out of the modulo accumulator.
  function automatic logic [ACC_W:0] add_wide(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] b);
    return {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
  endfunction

  assign w_start = (r_state == ST_IDLE) && bus.start;
  assign w_beat  = (r_state == ST_ACCUM) && bus.prod_valid;
  assign w_sum   = add_wide(r_acc, bus.prod);

  beat_counter #(.W(LEN_W)) u_beat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_start),
    .i_load_val (bus.len),
    .i_dec      (w_beat),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_ACCUM;
      ST_ACCUM: if (w_beat && w_zero) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Accumulator and sticky overflow; cleared on start, frozen outside ACCUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_beat) begin
      r_acc <= w_sum[ACC_W-1:0];
      if (w_sum[ACC_W]) r_ovf <= 1'b1;
    end
  end

  assign bus.prod_ready = (r_state == ST_ACCUM);
  assign bus.acc_valid  = (r_state == ST_DONE);
  assign bus.busy       = (r_state == ST_ACCUM) || (r_state == ST_DONE);
  assign bus.acc_out    = r_acc;
  assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_mul_accumulator.sv
// Drives identical product runs into a 12-bit and an 8-bit accumulator and checks both
// against the true integer sum of the accepted beats.
module tb_mul_accumulator;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic [7:0] prod;
  logic       prod_valid;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] beat_q[$];

  always #5 clk = ~clk;

  mul_accumulator_if #(.ACC_W(12)) ia ();
  mul_accumulator_if #(.ACC_W(8))  ib ();

  assign ia.start = start;      assign ib.start = start;
  assign ia.len = len;          assign ib.len = len;
  assign ia.prod = prod;        assign ib.prod = prod;
  assign ia.prod_valid = prod_valid;  assign ib.prod_valid = prod_valid;

  mul_accumulator #(.ACC_W(12)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  mul_accumulator #(.ACC_W(8))  dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag, input int sum);
    chk({tag, "_busy_a"}, 32'(ia.busy), 0);
    chk({tag, "_ready_a"}, 32'(ia.prod_ready), 0);
    chk({tag, "_vld_a"}, 32'(ia.acc_valid), 0);
    chk({tag, "_vld_b"}, 32'(ib.acc_valid), 0);
    chk({tag, "_acc_a"}, 32'(ia.acc_out), 32'(sum % 4096));
    chk({tag, "_acc_b"}, 32'(ib.acc_out), 32'(sum % 256));
  endtask

  // mode: 0 back-to-back, 1 valid toggles, 2 random stalls, 3 first beat delayed 5 cycles
  task automatic run(input string tag, input int l, input int mode, input bit mid_start);
    int sum = 0;
    int stall;
    start = 1'b1;
    len = 4'(l);
    prod_valid = 1'b0;
    step();
    start = 1'b0;
    len = 4'($urandom);
    chk({tag, "_ready"}, 32'(ia.prod_ready), 1);
    chk({tag, "_busy"}, 32'(ib.busy), 1);
    chk({tag, "_clr_a"}, 32'(ia.acc_out), 0);
    chk({tag, "_clr_ovf_b"}, 32'(ib.ovf), 0);
    for (int i = 0; i <= l; i++) begin
      stall = (mode == 1) ? int'(i > 0) :
              (mode == 2) ? int'($urandom_range(0, 3)) :
              (mode == 3 && i == 0) ? 5 : 0;
      for (int s = 0; s < stall; s++) begin
        prod_valid = 1'b0;
        prod = 8'($urandom);
        step();
        chk({tag, "_stall_ready"}, 32'(ia.prod_ready), 1);
        chk({tag, "_stall_acc"}, 32'(ia.acc_out), 32'(sum % 4096));
        chk({tag, "_stall_vld"}, 32'(ia.acc_valid), 0);
      end
      prod_valid = 1'b1;
      prod = beat_q[i];
      if (mid_start && i == 1) begin
        start = 1'b1;
        len = 4'd9;
      end
      step();
      start = 1'b0;
      sum += int'(beat_q[i]);
      if (i < l) chk({tag, "_mid_vld"}, 32'(ia.acc_valid), 0);
    end
    prod_valid = 1'b0;
    chk({tag, "_vld_a"}, 32'(ia.acc_valid), 1);
    chk({tag, "_vld_b"}, 32'(ib.acc_valid), 1);
    chk({tag, "_acc_a"}, 32'(ia.acc_out), 32'(sum % 4096));
    chk({tag, "_acc_b"}, 32'(ib.acc_out), 32'(sum % 256));
    chk({tag, "_ovf_a"}, 32'(ia.ovf), 32'(sum > 4095));
    chk({tag, "_ovf_b"}, 32'(ib.ovf), 32'(sum > 255));
    chk({tag, "_done_busy"}, 32'(ia.busy), 1);
    chk({tag, "_done_ready"}, 32'(ia.prod_ready), 0);
    step();
    chk_idle({tag, "_after"}, sum);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = 4'd0;
    prod = 8'd0;
    prod_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_idle("reset", 0);
    chk("reset_ovf_a", 32'(ia.ovf), 0);
    chk("reset_ovf_b", 32'(ib.ovf), 0);

    // Idle with start low holds everything
    step();
    chk_idle("idle_hold", 0);

    beat_q = {8'h0F, 8'h10, 8'hE1, 8'h01};
    run("s1", 3, 0, 1'b0);

    beat_q = {8'hE1};
    run("s2", 0, 3, 1'b0);

    beat_q = {};
    for (int i = 0; i < 16; i++) beat_q.push_back(8'hFF);
    run("s3_full", 15, 0, 1'b0);

    beat_q = {8'h80, 8'h80};
    run("s3_wrap", 1, 0, 1'b0);

    // Reset mid-run, colliding with a beat and a start
    start = 1'b1;
    len = 4'd2;
    step();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 8'd5;
    step();
    prod = 8'd6;
    step();
    rst = 1'b1;
    start = 1'b1;
    prod = 8'd9;
    step();
    rst = 1'b0;
    start = 1'b0;
    prod_valid = 1'b0;
    chk_idle("s4_rst", 0);
    chk("s4_rst_ovf", 32'(ib.ovf), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s4_no_vld", 32'(ia.acc_valid), 0);
    end
    beat_q = {8'd7};
    run("s4_fresh", 0, 0, 1'b0);

    beat_q = {8'd1, 8'd2, 8'd3};
    run("s5_ignore", 2, 0, 1'b1);
    beat_q = {8'd4, 8'd5};
    run("s5_b2b", 1, 0, 1'b0);

    beat_q = {8'h02, 8'h02, 8'h02, 8'h02};
    run("s6_toggle", 3, 1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      int l;
      l = int'($urandom_range(0, 15));
      beat_q = {};
      for (int i = 0; i <= l; i++) beat_q.push_back(8'($urandom));
      run("rand", l, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
